// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS word window, byte FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Handshake: a store is accepted on the clk edge where we & sel; the FIFO pops
  // only when the serialiser takes a byte (IDLE or end of STOP with !empty).
  state_t        state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    data_byte, byte_d;
  logic          tx_d, busy_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf, empty, full, push_req, push, pop, clr_ovf;
  logic          unused_bits;

  assign sel      = addr[31:3] == BASE_ADDR[31:3];
  assign empty    = count == '0;
  assign full     = count == COUNT_FULL;
  assign push_req = we && sel && !addr[2];
  assign push     = push_req && (!full || pop);
  assign clr_ovf  = we && sel && addr[2] && wdata[3];
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (clr_ovf)             ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      data_byte <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      baud      <= baud_d;
      bit_idx   <= bit_d;
      data_byte <= byte_d;
      tx        <= tx_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud + BW'(1);
    bit_d   = bit_idx;
    byte_d  = data_byte;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          byte_d  = mem[rd_ptr];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud == BAUD_LAST) begin
          baud_d = '0;
          // Back-to-back frames: take the next byte without passing through IDLE.
          if (!empty) begin
            pop     = 1'b1;
            byte_d  = mem[rd_ptr];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // tx/busy are computed from the next state so the flops change on the same edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_START:  tx_d   = 1'b0;
      S_DATA:   tx_d   = byte_d[bit_d];
      S_PARITY: tx_d   = ^byte_d;
      default:  tx_d   = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel && addr[2]) rdata = {28'b0, ovf, full, empty, busy};
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue-based frame model checked every cycle, plus literal frames.
// Honours UART_TX_PARITY_EN for the 8E1 build.
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] STAT  = 32'h0000_0104;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        we = 1'b0;
  logic [31:0] addr = STAT;
  logic [31:0] wdata = '0;
  logic        sel, tx, busy;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  // Model: bytes waiting in the FIFO, and the tx level for every remaining cycle of the frame.
  logic [7:0] exp_q[$];
  logic       line_q[$];
  logic       exp_ovf = 1'b0;

  logic        e_tx, e_busy, e_sel;
  logic [31:0] e_rd;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .sel(sel), .rdata(rdata), .tx(tx), .busy(busy)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd8);
  endfunction

  task automatic start_frame(input logic [7:0] b);
    logic [FRAME_BITS-1:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {1'b1, b, 1'b0};
`endif
    for (int i = 0; i < FRAME_BITS; i++)
      for (int k = 0; k < CPB; k++) line_q.push_back(f[i]);
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      if (line_q.size() > 0) line_q.delete(0);
      if (line_q.size() == 0 && exp_q.size() > 0) start_frame(exp_q.pop_front());
      if (we && in_window(addr)) begin
        if (addr < BASE + 32'd4) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(wdata[7:0]);
          else exp_ovf = 1'b1;
        end else if (wdata[3]) begin
          exp_ovf = 1'b0;
        end
      end
    end
  end

  // Every-cycle compare, away from the active edge
  always @(negedge clk) begin
    e_busy = line_q.size() > 0;
    e_tx   = e_busy ? line_q[0] : 1'b1;
    e_sel  = in_window(addr);
    check("tx", {31'b0, tx}, {31'b0, e_tx});
    check("busy", {31'b0, busy}, {31'b0, e_busy});
    check("sel", {31'b0, sel}, {31'b0, e_sel});
    if (e_sel) begin
      e_rd = (addr >= BASE + 32'd4) ?
             {28'b0, exp_ovf, exp_q.size() == DEPTH, exp_q.size() == 0, e_busy} : 32'h0;
      check("rdata", rdata, e_rd);
    end
  end

  // Driver tasks: called just after a rising edge, return just after a rising edge
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; addr = STAT; wdata = '0;
  endtask

  task automatic load(input logic [31:0] a);
    addr = a;
    @(posedge clk); #1;
    addr = STAT;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    @(negedge clk);
    check(name, rdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string name, input logic [FRAME_BITS-1:0] f);
    @(posedge clk);
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      check(name, {31'b0, tx}, {31'b0, f[i / CPB]});
      check({name, "_busy"}, {31'b0, busy}, 32'h1);
    end
    @(negedge clk);
    check({name, "_end_busy"}, {31'b0, busy}, 32'h0);
    check({name, "_end_status"}, rdata, 32'h2);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((busy || exp_q.size() > 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_budget", {31'b0, n < budget}, 32'h1);
  endtask

  task automatic reset_mid_frame();
    #2;
    reset = 1'b1;
    line_q.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_status", rdata, 32'h2);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [FRAME_BITS-1:0] frame55;
  int r;

  initial begin
`ifdef UART_TX_PARITY_EN
    frame55 = 11'b10_01010101_0;
`else
    frame55 = 10'b1_01010101_0;
`endif
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("init_tx", {31'b0, tx}, 32'h1);
    check("init_busy", {31'b0, busy}, 32'h0);
    check("init_status", rdata, 32'h2);
    @(posedge clk); #1;

    // Single literal frame
    store(BASE, 32'h55);
    check_frame("frame55", frame55);

    // Five stores while idle: first popped, FIFO left full
    for (int i = 0; i < 5; i++) store(BASE, 32'h41 + i);
    read_status("five_status", 32'h5);
    for (int i = 0; i < 6; i++) store(BASE + 32'(i % 4), 32'hE0 + i);
    read_status("ovf_set", 32'hD);
    store(STAT, 32'h8);
    read_status("ovf_clear", 32'h5);
    wait_drain(8 * FRAME_CYC);
    read_status("drained_status", 32'h2);

    // Reset mid-DATA
    store(BASE, 32'hA5);
    idle(3 * CPB);
    reset_mid_frame();
    idle(FRAME_CYC + 5);
    check("post_reset_busy", {31'b0, busy}, 32'h0);

    // Stores outside the window
    store(32'h0000_00FC, 32'h33);
    store(32'h0000_0108, 32'h34);
    load(BASE);
    idle(10);
    read_status("out_of_window_status", 32'h2);

`ifdef UART_TX_PARITY_EN
    store(BASE, 32'h07);
    check_frame("frame07", 11'b1_1_00000111_0);
`endif

    // Randomised traffic
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) store(BASE + $urandom_range(0, 3), $urandom);
      else if (r == 6) store(STAT + $urandom_range(0, 3), $urandom_range(0, 15));
      else if (r == 7) store(($urandom_range(0, 1) == 0) ? 32'h0000_00FC : 32'h0000_0108, $urandom);
      else if (r == 8) load(BASE + $urandom_range(0, 7));
      else load($urandom);
      idle($urandom_range(0, 20));
    end
    wait_drain(8 * FRAME_CYC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
